// File: rtl/sandpile_sweep_scheduler.sv
// Generation-tick prescaler plus IDLE/SWEEP/DRAIN sequencer that streams grid coordinates to the
// cell-update engine. Optional feature macro: STABLE_STOP_EN (halt sweeping once the grid settles).
module sandpile_sweep_scheduler #(
  parameter int PRESCALE = 1000,
  parameter int RES_W    = 9,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_active_i,
  input  logic [RES_W-1:0] resolution_i,
  input  logic [11:0]      speed_i,
  output logic             cell_valid_o,
  input  logic             cell_ready_i,
  output logic [RES_W-1:0] cell_x_o,
  output logic [RES_W-1:0] cell_y_o,
  output logic             cell_last_o,
  input  logic             topple_i,
  input  logic             engine_busy_i,
  output logic             sweep_active_o,
  output logic             stable_o,
  output logic [GEN_W-1:0] gen_count_o
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [RES_W-1:0] RES_ONE = RES_W'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [11:0]      rate_cnt_q, rate_cnt_d;
  logic [RES_W-1:0] n_q, n_d, x_q, x_d, y_q, y_d;
  logic             last_q, last_d;
  logic             pending_q, pending_d;
  logic             topple_seen_q, topple_seen_d;
  logic             stable_q, stable_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             base_tick, gen_tick, hold_stable, start;

  // NOTE: every signal written in always_comb gets a default first, so no latches are inferred.
  always_comb begin
    pre_cnt_d  = '0;
    rate_cnt_d = '0;
    base_tick  = 1'b0;
    gen_tick   = 1'b0;
    if (game_active_i) begin
      base_tick  = (pre_cnt_q == PRE_MAX);
      pre_cnt_d  = base_tick ? '0 : pre_cnt_q + PRE_W'(1);
      rate_cnt_d = rate_cnt_q;
      if (base_tick) begin
        if (rate_cnt_q == speed_i) begin
          gen_tick   = 1'b1;
          rate_cnt_d = '0;
        end else begin
          rate_cnt_d = rate_cnt_q + 12'd1;
        end
      end
    end
  end

`ifdef STABLE_STOP_EN
  // A settled grid stays parked until play stops or the requested size differs from the latched one.
  assign hold_stable = stable_q & game_active_i & (resolution_i == n_q);
`else
  assign hold_stable = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    x_d           = x_q;
    y_d           = y_q;
    pending_d     = pending_q;
    topple_seen_d = topple_seen_q;
    stable_d      = stable_q;
    gen_d         = gen_q;
    start         = 1'b0;

    if (state_q != IDLE) begin
      topple_seen_d = topple_seen_q | topple_i;
      if (gen_tick) pending_d = 1'b1;
    end
    if (!game_active_i) pending_d = 1'b0;
`ifdef STABLE_STOP_EN
    if (stable_q && !hold_stable) stable_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        start     = (gen_tick | pending_q) & game_active_i & (resolution_i != '0) & ~hold_stable;
        // Any tick seen here either launches a sweep now or is dropped; nothing is queued.
        pending_d = 1'b0;
        if (start) begin
          state_d       = SWEEP;
          n_d           = resolution_i;
          x_d           = '0;
          y_d           = '0;
          topple_seen_d = 1'b0;
        end
      end
      SWEEP: begin
        if (cell_ready_i) begin
          if (last_q) begin
            state_d = DRAIN;
          end else if (x_q == n_q - RES_ONE) begin
            x_d = '0;
            y_d = y_q + RES_ONE;
          end else begin
            x_d = x_q + RES_ONE;
          end
        end
      end
      DRAIN: begin
        if (!engine_busy_i) begin
          gen_d    = gen_q + GEN_W'(1);
          stable_d = ~topple_seen_d;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_d = (state_d == SWEEP) && (x_d == n_d - RES_ONE) && (y_d == n_d - RES_ONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      rate_cnt_q    <= '0;
      n_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      last_q        <= 1'b0;
      pending_q     <= 1'b0;
      topple_seen_q <= 1'b0;
      stable_q      <= 1'b0;
      gen_q         <= '0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      rate_cnt_q    <= rate_cnt_d;
      n_q           <= n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      topple_seen_q <= topple_seen_d;
      stable_q      <= stable_d;
      gen_q         <= gen_d;
    end
  end

  assign cell_valid_o   = (state_q == SWEEP);
  assign sweep_active_o = (state_q != IDLE);
  assign cell_x_o       = x_q;
  assign cell_y_o       = y_q;
  assign cell_last_o    = last_q;
  assign stable_o       = stable_q;
  assign gen_count_o    = gen_q;

endmodule

// File: tb/tb_sandpile_sweep_scheduler.sv
// Self-checking bench for sandpile_sweep_scheduler: raster-order scoreboard, arithmetic tick latency,
// per-sweep topple bookkeeping and generation count model.
module tb_sandpile_sweep_scheduler;

  localparam int PRESCALE = 4;
  localparam int RES_W    = 9;
  localparam int GEN_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             game_active_i;
  logic [RES_W-1:0] resolution_i;
  logic [11:0]      speed_i;
  logic             cell_valid_o;
  logic             cell_ready_i;
  logic [RES_W-1:0] cell_x_o;
  logic [RES_W-1:0] cell_y_o;
  logic             cell_last_o;
  logic             topple_i;
  logic             engine_busy_i;
  logic             sweep_active_o;
  logic             stable_o;
  logic [GEN_W-1:0] gen_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_gen  = 0;

  sandpile_sweep_scheduler #(.PRESCALE(PRESCALE), .RES_W(RES_W), .GEN_W(GEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .game_active_i (game_active_i),
    .resolution_i  (resolution_i),
    .speed_i       (speed_i),
    .cell_valid_o  (cell_valid_o),
    .cell_ready_i  (cell_ready_i),
    .cell_x_o      (cell_x_o),
    .cell_y_o      (cell_y_o),
    .cell_last_o   (cell_last_o),
    .topple_i      (topple_i),
    .engine_busy_i (engine_busy_i),
    .sweep_active_o(sweep_active_o),
    .stable_o      (stable_o),
    .gen_count_o   (gen_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Restart play from scratch (prescaler cleared) and wait for the first offered cell.
  task automatic start_play(input int n, input int spd, input bit chk_lat);
    int cyc;
    game_active_i = 1'b0;
    @(negedge clk);
    resolution_i  = RES_W'(n);
    speed_i       = 12'(spd);
    game_active_i = 1'b1;
    cyc = 0;
    while (!cell_valid_o && cyc < PRESCALE * (spd + 1) + 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("first_valid", cell_valid_o, 1);
    if (chk_lat) check("first_valid_latency", cyc, PRESCALE * (spd + 1));
  endtask

  // Drive one whole generation: raster scoreboard, drain with engine busy, then count/stable check.
  // rmode: 0 ready always, 1 ready toggling, 2 ready random.
  task automatic run_sweep(input int n, input int rmode, input int tp_pct, input int busy_len,
                           input bit drain_topple, input bit drop_act);
    int hs, cyc, ex_x, ex_y;
    bit tseen, rtog;
    hs = 0; cyc = 0; ex_x = 0; ex_y = 0; tseen = 1'b0; rtog = 1'b1;
    while (!cell_valid_o && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("sweep_start", cell_valid_o, 1);
    cyc = 0;
    while (hs < n * n && cyc < 8 * n * n + 16) begin
      case (rmode)
        0:       cell_ready_i = 1'b1;
        1:       begin cell_ready_i = rtog; rtog = ~rtog; end
        default: cell_ready_i = 1'($urandom_range(1));
      endcase
      topple_i = ($urandom_range(99) < tp_pct);
      tseen    = tseen | topple_i;
      if (cell_valid_o && cell_ready_i) begin
        check("cell_x", cell_x_o, ex_x);
        check("cell_y", cell_y_o, ex_y);
        check("cell_last", cell_last_o, (ex_x == n - 1) && (ex_y == n - 1));
        if (hs == 0 && drop_act) game_active_i = 1'b0;
        hs++;
        if (ex_x == n - 1) begin
          ex_x = 0;
          ex_y++;
        end else begin
          ex_x++;
        end
        if (hs == n * n) engine_busy_i = (busy_len > 0);
      end
      @(negedge clk);
      cyc++;
    end
    check("handshakes", hs, n * n);
    cell_ready_i = 1'b0;
    check("drain_valid", cell_valid_o, 0);
    check("drain_active", sweep_active_o, 1);
    for (int i = 0; i < busy_len; i++) begin
      topple_i = drain_topple && (i == 0);
      tseen    = tseen | topple_i;
      @(negedge clk);
    end
    if (busy_len > 0) check("drain_held", sweep_active_o, 1);
    engine_busy_i = 1'b0;
    topple_i      = (drain_topple && busy_len == 0) || ($urandom_range(99) < tp_pct);
    tseen         = tseen | topple_i;
    @(negedge clk);
    topple_i = 1'b0;
    exp_gen  = (exp_gen + 1) % (1 << GEN_W);
    check("gen_count", gen_count_o, exp_gen);
    check("stable", stable_o, !tseen);
    check("idle_after_drain", sweep_active_o, 0);
  endtask

  initial begin
    int g0, n_r, spd_r;
    bit any_valid;
    rst = 1'b1; game_active_i = 1'b0; resolution_i = '0; speed_i = '0;
    cell_ready_i = 1'b0; topple_i = 1'b0; engine_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", cell_valid_o, 0);
    check("reset_active", sweep_active_o, 0);
    check("reset_stable", stable_o, 0);
    check("reset_gen", gen_count_o, 0);
    check("reset_last", cell_last_o, 0);

    // N=3, speed=1, ready always: 8-clock first latency, full raster, count 0->1.
    start_play(3, 1, 1'b1);
    run_sweep(3, 0, 0, 3, 1'b0, 1'b0);

    // N=2 with ready toggling.
    start_play(2, 1, 1'b0);
    run_sweep(2, 1, 0, 2, 1'b0, 1'b0);

    // Topple in drain clears stable; next quiet sweep sets it again.
    start_play(2, 1, 1'b0);
    run_sweep(2, 0, 0, 3, 1'b1, 1'b0);
    run_sweep(2, 0, 0, 2, 1'b0, 1'b0);

`ifdef STABLE_STOP_EN
    any_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cell_valid_o) any_valid = 1'b1;
    end
    check("stop_no_valid", any_valid, 0);
    resolution_i = RES_W'(3);
    @(negedge clk);
    check("stop_stable_clear", stable_o, 0);
    run_sweep(3, 0, 0, 1, 1'b0, 1'b0);
`endif

    // speed=0 with long drain: one pending sweep follows right away, then play stops mid-sweep.
    g0 = exp_gen;
    start_play(2, 0, 1'b0);
    run_sweep(2, 0, 0, 20, 1'b1, 1'b0);
    check("pending_idle", cell_valid_o, 0);
    @(negedge clk);
    check("pending_start", cell_valid_o, 1);
    run_sweep(2, 0, 0, 0, 1'b0, 1'b1);
    any_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cell_valid_o) any_valid = 1'b1;
    end
    check("no_sweep_after_drop", any_valid, 0);
    check("gen_plus_two", gen_count_o, g0 + 2);

    // Reset in the middle of a sweep.
    start_play(4, 0, 1'b0);
    cell_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", cell_valid_o, 0);
    check("rst_mid_active", sweep_active_o, 0);
    check("rst_mid_gen", gen_count_o, 0);
    exp_gen = 0;
    cell_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(4, 2, 0, 2, 1'b0, 1'b0);

    // Randomized generations.
    for (int it = 0; it < 8; it++) begin
      n_r   = 1 + int'($urandom_range(4));
      spd_r = int'($urandom_range(2));
      start_play(n_r, spd_r, 1'b1);
      run_sweep(n_r, 2, ($urandom_range(1) == 1) ? 4 : 0, int'($urandom_range(5)),
                1'($urandom_range(1)), 1'b0);
    end

    game_active_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
